// File: rtl/cdc_handshake_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdc_handshake_arbiter                                        |
// | Description : Round-robin arbiter that shares a single 4-phase handshake    |
// |               clock-domain crossing between N_REQ requesters. One transfer  |
// |               is in flight at a time. The payload is held stable for the    |
// |               whole handshake.                                              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1             single clock, posedge                       |
// |   rst        in   1             synchronous active-high reset               |
// |   req        in   N_REQ         level request per requester                 |
// |   req_data   in   N_REQ*DATA_W  payload, slice i = [i*DATA_W +: DATA_W]     |
// |   done       out  N_REQ         one-hot 1-cycle completion pulse            |
// |   err        out  1             pulses with done when the transfer timed out|
// |   busy       out  1             high whenever the FSM is not idle           |
// |   xfer_stb   out  1             registered strobe to the crossing cell      |
// |   xfer_data  out  DATA_W        registered payload to the crossing cell     |
// |   xfer_ack   in   1             ack from the far side, already synchronized |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   CDC_ARB_TIMEOUT_EN : when defined, the strobe phase gives up after       |
// |                        TIMEOUT cycles without an ack and err pulses with   |
// |                        done. When undefined, the strobe waits forever and  |
// |                        err is tied low.                                    |
// +----------------------------------------------------------------------------+
module cdc_handshake_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic                    busy,
  output logic                    xfer_stb,
  output logic [DATA_W-1:0]       xfer_data,
  input  logic                    xfer_ack
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STB   = 2'd1;
  localparam logic [1:0] S_ACKLO = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_ptr_next;
  logic             w_found;
  logic             w_launch;
  logic             w_expire;
  logic [DATA_W-1:0] w_slice [N_REQ];
  int               w_pos;

  // Per-requester payload slices and the done decode. done comes straight
  // from registered state/index, so it cannot glitch.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_slice[gi] = req_data[gi*DATA_W +: DATA_W];
      assign done[gi]    = (r_state == S_DONE) && (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(r_ptr) + k;
      if (w_pos >= N_REQ) begin
        w_pos = w_pos - N_REQ;
      end
      if (!w_found && req[w_pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_pos[IDX_W-1:0];
      end
    end
  end

  // A high ack in IDLE is stale (left over from a reset or the far side
  // lagging); launching on it would break the 4-phase protocol.
  assign w_launch   = w_found && !xfer_ack;
  assign w_ptr_next = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
  assign busy       = (r_state != S_IDLE);

`ifdef CDC_ARB_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] r_tcnt;
  logic [TIMEOUT_BITS-1:0] w_tcnt_next;
  logic                    r_tmo;

  // r_tcnt counts completed STB cycles; expiry fires on the cycle that
  // would bring the count to TIMEOUT, so the strobe is high TIMEOUT cycles.
  assign w_tcnt_next = r_tcnt + 1'b1;
  assign w_expire    = (w_tcnt_next == TIMEOUT_BITS'(TIMEOUT));
  assign err         = (r_state == S_DONE) && r_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_tmo  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_launch) begin
        r_tcnt <= '0;
        r_tmo  <= 1'b0;
      end
    end else if (r_state == S_STB && !xfer_ack) begin
      // An ack on the expiry edge takes the normal path: r_tmo stays clear.
      r_tcnt <= w_tcnt_next;
      if (w_expire) begin
        r_tmo <= 1'b1;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_expire     = 1'b0;
  assign err          = 1'b0;
  assign w_unused_cfg = TIMEOUT[0] ^ TIMEOUT_BITS[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      xfer_stb  <= 1'b0;
      xfer_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_idx     <= w_pick;
            xfer_data <= w_slice[w_pick];
            xfer_stb  <= 1'b1;
            r_state   <= S_STB;
          end
        end
        S_STB: begin
          if (xfer_ack || w_expire) begin
            xfer_stb <= 1'b0;
            r_state  <= S_ACKLO;
          end
        end
        S_ACKLO: begin
          if (!xfer_ack) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // The winner moves to the lowest priority slot.
          r_ptr   <= w_ptr_next;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cdc_handshake_arbiter                                     |
// | Description : Directed self-checking bench for cdc_handshake_arbiter.      |
// |               Inputs change and outputs are sampled on the falling edge.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cdc_handshake_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   done;
  logic         err;
  logic         busy;
  logic         xfer_stb;
  logic [31:0]  xfer_data;
  logic         xfer_ack;

  // Far-side model: either echo the strobe one cycle late or drive by hand.
  logic echo_en;
  logic man_ack;
  logic r_echo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) r_echo <= rst ? 1'b0 : xfer_stb;

  assign xfer_ack = echo_en ? r_echo : man_ack;

  cdc_handshake_arbiter #(
    .N_REQ        (4),
    .DATA_W       (32),
    .TIMEOUT      (10),
    .TIMEOUT_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .xfer_stb  (xfer_stb),
    .xfer_data (xfer_data),
    .xfer_ack  (xfer_ack)
  );

  task automatic do_reset(input logic ack_lvl);
    echo_en = 1'b0;
    man_ack = ack_lvl;
    req     = '0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = base + 32'(i);
  endtask

  // Waits (bounded) for a done pulse; returns it, the first payload seen
  // with the strobe and the number of falling edges waited. Returns d=0 on
  // timeout so the caller's comparison flags it.
  task automatic wait_done(output logic [3:0] d, output logic [31:0] dat,
                           output int cyc);
    bit seen;
    d    = '0;
    dat  = '0;
    cyc  = 0;
    seen = 1'b0;
    while (d == 4'b0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (xfer_stb && !seen) begin
        dat  = xfer_data;
        seen = 1'b1;
      end
      if (done != 4'b0) d = done;
    end
  endtask

  // One full transfer with the echo model; drops the request on done.
  task automatic run_one(input logic [3:0] req_v, input logic [3:0] exp_d,
                         input logic [31:0] exp_dat, input string name);
    logic [3:0]  d;
    logic [31:0] dat;
    int          cyc;
    echo_en = 1'b1;
    req     = req_v;
    wait_done(d, dat, cyc);
    checks++;
    if (d !== exp_d) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, d, exp_d);
    end
    checks++;
    if (dat !== exp_dat) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", name, dat, exp_dat);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses;
    echo_en  = 1'b0;
    man_ack  = 1'b0;
    req      = '0;
    req_data = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({xfer_stb, busy, err, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got stb=%b busy=%b err=%b done=%b expected all 0",
               xfer_stb, busy, err, done);
    end
    checks++;
    if (xfer_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00000000", xfer_data);
    end
    rst = 1'b0;
    req_data[31:0] = 32'h0000_0055;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (xfer_stb !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prelaunch: got stb=%b busy=%b expected 1 1", xfer_stb, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (xfer_stb !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL reset_abort_first: got stb=%b busy=%b done=%b expected 0 0 0000",
               xfer_stb, busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = '0;
    checks++;
    if (xfer_stb !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL reset_abort_hold: got stb=%b busy=%b done=%b expected 0 0 0000",
               xfer_stb, busy, done);
    end
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 4'b0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d active cycles expected 0", pulses);
    end
  endtask

  task automatic test_single();
    logic [3:0]  d;
    logic [31:0] dat;
    int          cyc;
    do_reset(1'b0);
    set_data(32'h2000_0000);
    req_data[2*32 +: 32] = 32'hDEAD_BEEF;
    echo_en = 1'b1;
    req     = 4'b0100;
    wait_done(d, dat, cyc);
    checks++;
    if (dat !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_data: got %h expected deadbeef", dat);
    end
    checks++;
    if (d !== 4'b0100) begin
      errors++;
      $display("FAIL single_done: got %b expected 0100", d);
    end
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 5", cyc);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL single_err: got %b expected 0", err);
    end
    req = '0;
    @(negedge clk);
  endtask

  // Runs right after test_single, so the pointer sits at 3.
  task automatic test_wrap();
    run_one(4'b1000, 4'b1000, 32'h2000_0003, "wrap_grant3");
    run_one(4'b0001, 4'b0001, 32'h2000_0000, "wrap_grant0");
    run_one(4'b1111, 4'b0010, 32'h2000_0001, "wrap_ptr1");
  endtask

  task automatic test_round_robin();
    int          exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  d;
    logic [3:0]  e;
    logic [31:0] dat;
    int          cyc;
    do_reset(1'b0);
    set_data(32'h1000_0000);
    echo_en = 1'b1;
    req     = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(d, dat, cyc);
      e = 4'b0001 << exp_idx[n];
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", n, d, e);
      end
      checks++;
      if (dat !== 32'h1000_0000 + 32'(exp_idx[n])) begin
        errors++;
        $display("FAIL rr_data%0d: got %h expected %h", n, dat,
                 32'h1000_0000 + 32'(exp_idx[n]));
      end
      req = 4'b1111 & ~d;
      @(negedge clk);
      req = (n < 4) ? 4'b1111 : 4'b0000;
    end
    @(negedge clk);
  endtask

  task automatic test_stale_ack();
    int bad;
    do_reset(1'b1);
    req_data[31:0] = 32'h0A0A_0A0A;
    req = 4'b0001;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (xfer_stb !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_hold: got %0d launched cycles expected 0", bad);
    end
    man_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (xfer_stb !== 1'b1) begin
      errors++;
      $display("FAIL stale_launch: got stb=%b expected 1", xfer_stb);
    end
    man_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (xfer_stb !== 1'b0) begin
      errors++;
      $display("FAIL stale_stb_drop: got stb=%b expected 0", xfer_stb);
    end
    man_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL stale_done: got %b expected 0001", done);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad;
    int cnt;
    do_reset(1'b0);
    req_data[31:0] = 32'h7777_0000;
    req = 4'b0001;
`ifdef CDC_ARB_TIMEOUT_EN
    cnt = 0;
    bad = 0;
    while (bad < 40) begin
      @(negedge clk);
      bad++;
      if (xfer_stb) cnt++;
      else if (cnt > 0) bad = 40;
    end
    checks++;
    if (cnt != 10) begin
      errors++;
      $display("FAIL tmo_stb_len: got %0d expected 10", cnt);
    end
    checks++;
    if (done !== 4'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got done=%b err=%b expected 0000 0", done, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_done_err: got done=%b err=%b expected 0001 1", done, err);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== 4'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_len: got done=%b err=%b expected 0000 0", done, err);
    end
`else
    cnt = 0;
    bad = 0;
    @(negedge clk);
    repeat (300) begin
      @(negedge clk);
      cnt++;
      if (xfer_stb !== 1'b1 || err !== 1'b0 || done !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL notmo_wait: got %0d bad cycles of %0d expected 0", bad, cnt);
    end
    do_reset(1'b0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_stale_ack();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
